// File: rtl/execute_pkg.sv
// Shared types, constants and helpers for the RV64 execute stage.
// Pulled into the stage and its mul/div unit with import execute_pkg::*.
package execute_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] MIN_S64 = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [31:0] MIN_S32 = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_NONE, OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP
    } op_t;

    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
        ADDW, SUBW, SLLW, SRLW, SRAW,
        MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
    } alufunc_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

    typedef struct packed {
        op_t      op;
        alufunc_t alufunc;
    } ctl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     raw_instr;
        logic [4:0]      dst;
        logic [XLEN-1:0] srca;
        logic [XLEN-1:0] srcb;
        ctl_t            ctl;
    } decode_data_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     raw_instr;
        logic [4:0]      dst;
        logic [XLEN-1:0] aluout;
        ctl_t            ctl;
    } execute_data_t;

    function automatic logic is_muldiv(alufunc_t f);
        return f inside {MUL, MULW, DIV, DIVU, REM, REMU,
                         DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative RV64M unit: shift-add multiply, restoring divide.
// Operands are held as magnitudes; signs are fixed up on completion.
module execute_muldiv
    import execute_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  alufunc_t        op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    muldiv_state_t   state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   acc_q;
    logic [XLEN-1:0] a_q, b_q, result_q;
    logic            is_mul_q, is_rem_q, w_q, qneg_q, rneg_q;

    logic            mul_op, rem_op, w_op, s_op;
    logic [XLEN-1:0] xa, xb, ma, mb, min_x, early_raw, early_res;
    logic            dz, ovf;
    logic [XLEN:0]   acc_d;
    logic [XLEN-1:0] a_d, b_d, quo, rem_v, raw, fin;

    // Classify the incoming op.
    always_comb begin
        mul_op = 1'b0;
        rem_op = 1'b0;
        w_op   = 1'b0;
        s_op   = 1'b0;
        unique case (op_i)
            MUL:   mul_op = 1'b1;
            MULW:  begin mul_op = 1'b1; w_op = 1'b1; end
            DIV:   s_op = 1'b1;
            REM:   begin rem_op = 1'b1; s_op = 1'b1; end
            REMU:  rem_op = 1'b1;
            DIVW:  begin w_op = 1'b1; s_op = 1'b1; end
            DIVUW: w_op = 1'b1;
            REMW:  begin rem_op = 1'b1; w_op = 1'b1; s_op = 1'b1; end
            REMUW: begin rem_op = 1'b1; w_op = 1'b1; end
            default: ;
        endcase
    end

    // Extend W operands, take magnitudes, detect the early-out cases.
    always_comb begin
        xa = w_op ? (s_op ? sext32(a_i[31:0])
                          : {{(XLEN-32){1'b0}}, a_i[31:0]}) : a_i;
        xb = w_op ? (s_op ? sext32(b_i[31:0])
                          : {{(XLEN-32){1'b0}}, b_i[31:0]}) : b_i;
        ma = (s_op && xa[XLEN-1]) ? -xa : xa;
        mb = (s_op && xb[XLEN-1]) ? -xb : xb;
        min_x = w_op ? sext32(MIN_S32) : MIN_S64;
        dz  = ~mul_op & (xb == '0);
        ovf = s_op & (xa == min_x) & (xb == '1);
        if (dz) early_raw = rem_op ? xa : '1;
        else    early_raw = rem_op ? '0 : xa;
        early_res = w_op ? sext32(early_raw[31:0]) : early_raw;
    end

    // Resolve BITS_PER_CYCLE bits and form the signed final result.
    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_mul_q) begin
                if (b_d[0]) acc_d = acc_d + {1'b0, a_d};
                a_d = a_d << 1;
                b_d = b_d >> 1;
            end else begin
                acc_d = {acc_d[XLEN-1:0], a_d[XLEN-1]};
                a_d   = a_d << 1;
                if (acc_d >= {1'b0, b_d}) begin
                    acc_d  = acc_d - {1'b0, b_d};
                    a_d[0] = 1'b1;
                end
            end
        end
        quo   = qneg_q ? -a_d : a_d;
        rem_v = rneg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        raw   = is_mul_q ? acc_d[XLEN-1:0] : (is_rem_q ? rem_v : quo);
        fin   = w_q ? sext32(raw[31:0]) : raw;
    end

    // Control FSM and iterative datapath registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            w_q      <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start_i) begin
                    is_mul_q <= mul_op;
                    is_rem_q <= rem_op;
                    w_q      <= w_op;
                    qneg_q   <= s_op & (xa[XLEN-1] ^ xb[XLEN-1]);
                    rneg_q   <= s_op & xa[XLEN-1];
                    acc_q    <= '0;
                    a_q      <= mul_op ? xa : ma;
                    b_q      <= mul_op ? xb : mb;
                    cnt_q    <= CW'(ITERS - 1);
                    if (dz || ovf) begin
                        result_q <= early_res;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        result_q <= fin;
                        state_q  <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = ~rst_i & ~flush_i &
                    (((state_q == IDLE) & start_i) | (state_q == BUSY));
    assign done_o = ~rst_i & ~flush_i & (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: rtl/execute.sv
// RV64 execute stage: single-cycle ALU plus iterative mul/div.
// stallE holds decode while the mul/div unit is working.
module execute
    import execute_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  decode_data_t  dataD,
    input  logic          flush,
    output execute_data_t dataE,
    output logic          stallE
);

    logic            md_sel, md_start, md_busy, md_done;
    logic [XLEN-1:0] md_result, alu_y, a, b;
    logic [31:0]     w32;
    logic [5:0]      sh;
    logic [4:0]      shw;

    assign a   = dataD.srca;
    assign b   = dataD.srcb;
    assign sh  = b[5:0];
    assign shw = b[4:0];

    assign md_sel   = is_muldiv(dataD.ctl.alufunc);
    assign md_start = dataD.valid & md_sel;

    execute_muldiv #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_muldiv (
        .clk     (clk),
        .rst_i   (reset),
        .start_i (md_start),
        .flush_i (flush),
        .op_i    (dataD.ctl.alufunc),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .result_o(md_result)
    );

    // Single-cycle integer ALU; W ops work on 32 bits and sign-extend.
    always_comb begin
        alu_y = '0;
        w32   = '0;
        unique case (dataD.ctl.alufunc)
            ADD:  alu_y = a + b;
            SUB:  alu_y = a - b;
            AND:  alu_y = a & b;
            OR:   alu_y = a | b;
            XOR:  alu_y = a ^ b;
            SLL:  alu_y = a << sh;
            SRL:  alu_y = a >> sh;
            SRA:  alu_y = $signed(a) >>> sh;
            SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU: alu_y = {{(XLEN-1){1'b0}}, a < b};
            ADDW: begin w32 = a[31:0] + b[31:0]; alu_y = sext32(w32); end
            SUBW: begin w32 = a[31:0] - b[31:0]; alu_y = sext32(w32); end
            SLLW: begin w32 = a[31:0] << shw; alu_y = sext32(w32); end
            SRLW: begin w32 = a[31:0] >> shw; alu_y = sext32(w32); end
            SRAW: begin
                w32   = $signed(a[31:0]) >>> shw;
                alu_y = sext32(w32);
            end
            default: alu_y = '0;
        endcase
    end

    // Output bundle: pass-through fields plus the selected result.
    always_comb begin
        dataE.pc        = dataD.pc;
        dataE.raw_instr = dataD.raw_instr;
        dataE.dst       = dataD.dst;
        dataE.ctl       = dataD.ctl;
        dataE.aluout    = md_sel ? md_result : alu_y;
        dataE.valid     = md_sel ? md_done
                                 : (dataD.valid & ~flush & ~reset);
    end

    assign stallE = md_busy;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage.
// Directed and random ALU / mul/div ops against an arithmetic model.
module tb_execute;
    import execute_pkg::*;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam int MD_STALLS = 65;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    decode_data_t  dD;
    execute_data_t dE;
    logic          stallE;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk   (clk),
        .reset (reset),
        .dataD (dD),
        .flush (flush),
        .dataE (dE),
        .stallE(stallE)
    );

    alufunc_t alf[15] = '{ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
                          ADDW, SUBW, SLLW, SRLW, SRAW};
    alufunc_t mdf[10] = '{MUL, MULW, DIV, DIVU, REM, REMU,
                          DIVW, DIVUW, REMW, REMUW};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input alufunc_t f,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        longint sa, sb;
        int sa32, sb32;
        logic [31:0] ua, ub;
        logic ov, ov32;
        sa = a; sb = b; ua = a[31:0]; ub = b[31:0];
        sa32 = ua; sb32 = ub;
        ov = (a == MINV) && (b == '1);
        ov32 = (ua == 32'h8000_0000) && (ub == '1);
        case (f)
            ADD:  return a + b;
            SUB:  return a - b;
            AND:  return a & b;
            OR:   return a | b;
            XOR:  return a ^ b;
            SLL:  return a << b[5:0];
            SRL:  return a >> b[5:0];
            SRA:  return sa >>> b[5:0];
            SLT:  return (sa < sb) ? 64'd1 : 64'd0;
            SLTU: return (a < b) ? 64'd1 : 64'd0;
            ADDW: return sx(ua + ub);
            SUBW: return sx(ua - ub);
            SLLW: return sx(ua << b[4:0]);
            SRLW: return sx(ua >> b[4:0]);
            SRAW: return sx(sa32 >>> b[4:0]);
            MUL:  return a * b;
            MULW: return sx(ua * ub);
            DIV: begin
                if (b == 0) return '1;
                if (ov) return MINV;
                return sa / sb;
            end
            DIVU: begin
                if (b == 0) return '1;
                return a / b;
            end
            REM: begin
                if (b == 0) return a;
                if (ov) return 64'd0;
                return sa % sb;
            end
            REMU: begin
                if (b == 0) return a;
                return a % b;
            end
            DIVW: begin
                if (ub == 0) return '1;
                if (ov32) return sx(32'h8000_0000);
                return sx(sa32 / sb32);
            end
            DIVUW: begin
                if (ub == 0) return '1;
                return sx(ua / ub);
            end
            REMW: begin
                if (ub == 0) return sx(ua);
                if (ov32) return 64'd0;
                return sx(sa32 % sb32);
            end
            REMUW: begin
                if (ub == 0) return sx(ua);
                return sx(ua % ub);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_stalls(input alufunc_t f,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
        bit w, s, z, o;
        w = f inside {DIVW, DIVUW, REMW, REMUW};
        s = f inside {DIV, REM, DIVW, REMW};
        if (f inside {MUL, MULW}) return MD_STALLS;
        z = w ? (b[31:0] == 0) : (b == 0);
        o = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
              : (a == MINV && b == '1);
        if (z || (s && o)) return 1;
        return MD_STALLS;
    endfunction

    task automatic drive(input logic v, input alufunc_t f,
                         input logic [63:0] a, input logic [63:0] b);
        dD.valid       = v;
        dD.pc          = {$urandom, $urandom};
        dD.raw_instr   = $urandom;
        dD.dst         = 5'($urandom);
        dD.srca        = a;
        dD.srcb        = b;
        dD.ctl.op      = OP_ALU;
        dD.ctl.alufunc = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string tag, input logic v, input alufunc_t f,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        drive(v, f, a, b);
        @(negedge clk);
        chk({tag, " stall"}, 64'(stallE), 64'd0);
        chk({tag, " valid"}, 64'(dE.valid), 64'(v));
        if (v) chk({tag, " aluout"}, dE.aluout, exp);
        chk({tag, " pc"}, dE.pc, dD.pc);
        step();
    endtask

    task automatic md_op(input string tag, input alufunc_t f,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int stalls);
        int n;
        drive(1'b1, f, a, b);
        n = 0;
        @(negedge clk);
        while (stallE === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " stalls"}, 64'(n), 64'(stalls));
        chk({tag, " valid"}, 64'(dE.valid), 64'd1);
        chk({tag, " aluout"}, dE.aluout, exp);
        chk({tag, " dst"}, 64'(dE.dst), 64'(dD.dst));
        step();
    endtask

    logic         prev_stall = 1'b0;
    decode_data_t prev_d;

    // dataD must be held while the stage is stalled.
    always @(negedge clk) begin
        if (prev_stall) begin
            total++;
            assert (dD === prev_d) else begin
                bad++;
                $error("FAIL hold_dataD observed=%h expected=%h", dD, prev_d);
            end
        end
        prev_stall = stallE;
        prev_d     = dD;
    end

    initial begin
        logic [63:0] a, b;
        alufunc_t    f;
        int          sel;

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, MUL, 64'd3, 64'd5);
        @(negedge clk);
        chk("reset stall", 64'(stallE), 64'd0);
        chk("reset valid", 64'(dE.valid), 64'd0);
        step();
        reset = 1'b0;
        drive(1'b0, ADD, 64'd0, 64'd0);
        @(negedge clk);
        chk("post-reset stall", 64'(stallE), 64'd0);
        chk("post-reset valid", 64'(dE.valid), 64'd0);
        step();

        alu_op("add 5+7", 1'b1, ADD, 64'd5, 64'd7, 64'd12);

        md_op("mul -3*4", MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4,
              64'hFFFF_FFFF_FFFF_FFF4, MD_STALLS);
        drive(1'b0, ADD, 64'd0, 64'd0);
        @(negedge clk);
        chk("after mul stall", 64'(stallE), 64'd0);
        chk("after mul valid", 64'(dE.valid), 64'd0);
        step();

        md_op("div -7/2", DIV, -64'sd7, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, MD_STALLS);
        md_op("rem -7/2", REM, -64'sd7, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, MD_STALLS);
        md_op("divuw", DIVUW, 64'h1_0000_0010, 64'd4, 64'd4, MD_STALLS);
        md_op("div 9/0", DIV, 64'd9, 64'd0, '1, 1);
        md_op("rem 9/0", REM, 64'd9, 64'd0, 64'd9, 1);
        md_op("div min/-1", DIV, MINV, '1, MINV, 1);
        md_op("remw min/-1", REMW, 64'h8000_0000, '1, 64'd0, 1);

        drive(1'b1, DIV, 64'd10, 64'd3);
        flush = 1'b1;
        @(negedge clk);
        chk("flush-accept stall", 64'(stallE), 64'd0);
        chk("flush-accept valid", 64'(dE.valid), 64'd0);
        step();
        flush = 1'b0;
        drive(1'b0, DIV, 64'd10, 64'd3);
        @(negedge clk);
        chk("flush-accept idle", 64'(stallE), 64'd0);
        step();

        drive(1'b1, DIVU, 64'd1000, 64'd7);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush busy stall", 64'(stallE), 64'd0);
        chk("flush busy valid", 64'(dE.valid), 64'd0);
        step();
        flush = 1'b0;
        alu_op("add 1+1", 1'b1, ADD, 64'd1, 64'd1, 64'd2);

        drive(1'b1, MUL, 64'd123, 64'd456);
        for (int i = 0; i < 30; i++) step();
        reset = 1'b1;
        @(negedge clk);
        chk("reset busy stall", 64'(stallE), 64'd0);
        chk("reset busy valid", 64'(dE.valid), 64'd0);
        step();
        reset = 1'b0;
        drive(1'b0, MUL, 64'd0, 64'd0);
        @(negedge clk);
        chk("after reset stall", 64'(stallE), 64'd0);
        chk("after reset valid", 64'(dE.valid), 64'd0);
        step();

        md_op("mul b2b 1", MUL, 64'h1234_5678_9ABC_DEF0, 64'd77,
              model(MUL, 64'h1234_5678_9ABC_DEF0, 64'd77), MD_STALLS);
        md_op("mul b2b 2", MUL, 64'd6, 64'd7, 64'd42, MD_STALLS);

        for (int i = 0; i < 40; i++) begin
            f = alf[$urandom_range(0, 14)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            alu_op($sformatf("alu[%0d] %s", i, f.name()),
                   1'($urandom_range(0, 3) != 0), f, a, b, model(f, a, b));
        end

        for (int i = 0; i < 20; i++) begin
            f = mdf[$urandom_range(0, 9)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 64'd0;
            if (sel == 1) begin
                a = $urandom_range(0, 1) ? MINV : 64'h8000_0000;
                b = '1;
            end
            if (sel == 2) b = 64'($urandom_range(1, 255));
            if (sel == 3) a = -64'($urandom_range(0, 255));
            md_op($sformatf("md[%0d] %s", i, f.name()), f, a, b,
                  model(f, a, b), exp_stalls(f, a, b));
        end

        drive(1'b0, ADD, 64'd0, 64'd0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
